// File: rtl/spmv_radix_pkg.sv
// Shared types and constants for the float-to-fixed input converter.
// Format codes, per-format exponent geometry and the unpacked operand.
package spmv_radix_pkg;

  localparam logic [1:0] FMT_HALF   = 2'd0;
  localparam logic [1:0] FMT_SINGLE = 2'd1;
  localparam logic [1:0] FMT_DOUBLE = 2'd2;

  localparam int EXP_W_H = 5;
  localparam int EXP_W_S = 8;
  localparam int EXP_W_D = 11;

  localparam logic [11:0] BIAS_H = 12'd15;
  localparam logic [11:0] BIAS_S = 12'd127;
  localparam logic [11:0] BIAS_D = 12'd1023;

  typedef struct packed {
    logic        sign;
    logic [11:0] e;
    logic [52:0] m;
    logic        is_inf;
    logic        is_nan;
    logic        is_zero;
  } unpk_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational decode of a half/single/double beat into a common
// form: unbiased exponent and 53-bit mantissa with explicit hidden bit.
module fp_unpack
  import spmv_radix_pkg::*;
(
  input  logic [1:0]  i_fmt,
  input  logic [63:0] i_data,
  output unpk_t       o_unpk
);

  logic        w_sign;
  logic [10:0] w_exp;
  logic [10:0] w_exp_max;
  logic [51:0] w_frac;
  logic [11:0] w_bias;
  logic        w_exp_zero;
  logic        w_exp_ones;
  logic        w_frac_nz;

  // Reserved code 3 falls through to double.
  always_comb begin
    w_sign    = i_data[63];
    w_exp     = i_data[62:52];
    w_frac    = i_data[51:0];
    w_exp_max = 11'((1 << EXP_W_D) - 1);
    w_bias    = BIAS_D;
    case (i_fmt)
      FMT_HALF: begin
        w_sign    = i_data[15];
        w_exp     = {6'd0, i_data[14:10]};
        w_frac    = {i_data[9:0], 42'd0};
        w_exp_max = 11'((1 << EXP_W_H) - 1);
        w_bias    = BIAS_H;
      end
      FMT_SINGLE: begin
        w_sign    = i_data[31];
        w_exp     = {3'd0, i_data[30:23]};
        w_frac    = {i_data[22:0], 29'd0};
        w_exp_max = 11'((1 << EXP_W_S) - 1);
        w_bias    = BIAS_S;
      end
      default: ;
    endcase
  end

  assign w_exp_zero = (w_exp == 11'd0);
  assign w_exp_ones = (w_exp == w_exp_max);
  assign w_frac_nz  = |w_frac;

  always_comb begin
    o_unpk         = '0;
    o_unpk.sign    = w_sign;
    o_unpk.e       = w_exp_zero ? (12'd1 - w_bias)
                                : ({1'b0, w_exp} - w_bias);
    o_unpk.m       = {~w_exp_zero, w_frac};
    o_unpk.is_inf  = w_exp_ones & ~w_frac_nz;
    o_unpk.is_nan  = w_exp_ones & w_frac_nz;
    o_unpk.is_zero = w_exp_zero & ~w_frac_nz;
  end

endmodule

// File: rtl/radix_converter_fwd.sv
// IEEE half/single/double to signed fixed-point, 3-stage elastic
// pipeline: unpack -> align -> sign/saturate.
module radix_converter_fwd
  import spmv_radix_pkg::*;
#(
  parameter int FIX_W     = 64,
  parameter int FRAC_BITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       Ctrl_sig,
  input  logic             input_valid,
  output logic             input_ready,
  input  logic [63:0]      input_data,
  output logic             output_valid,
  input  logic             output_ready,
  output logic [FIX_W-1:0] output_data,
  output logic             output_ovf,
  output logic             output_nan
);

  localparam int WW = FIX_W + 53;
  localparam logic signed [13:0] SH_LIM  = 14'(FIX_W);
  localparam logic signed [14:0] TOP_LIM = 15'(FIX_W - 1);
  localparam logic [FIX_W-1:0] MAX_POS = {1'b0, {(FIX_W-1){1'b1}}};
  localparam logic [FIX_W-1:0] MIN_NEG = {1'b1, {(FIX_W-1){1'b0}}};

  logic w_ld1, w_ld2, w_ld3;
  logic r_v1, r_v2, r_v3;

  unpk_t w_unpk;
  unpk_t r_s1;

  logic             r_s2_sign;
  logic             r_s2_ovf;
  logic             r_s2_inf;
  logic             r_s2_nan;
  logic [FIX_W-1:0] r_s2_mag;

  logic [FIX_W-1:0] r_out_data;
  logic             r_out_ovf;
  logic             r_out_nan;

  assign w_ld3 = ~r_v3 | output_ready;
  assign w_ld2 = ~r_v2 | w_ld3;
  assign w_ld1 = ~r_v1 | w_ld2;

  assign input_ready  = w_ld1;
  assign output_valid = r_v3;
  assign output_data  = r_out_data;
  assign output_ovf   = r_out_ovf;
  assign output_nan   = r_out_nan;

  fp_unpack u_unpack (
    .i_fmt  (Ctrl_sig),
    .i_data (input_data),
    .o_unpk (w_unpk)
  );

  logic signed [13:0] w_shift;
  logic        [13:0] w_rsh;
  logic        [5:0]  w_msb;
  logic signed [14:0] w_top;
  logic [WW-1:0]      w_wide;
  logic [FIX_W-1:0]   w_mag;
  logic               w_ovf;

  // Align: S = E - 52 + FRAC_BITS, left for S >= 0, truncating right otherwise.
  always_comb begin
    w_msb = '0;
    for (int i = 0; i < 53; i++) begin
      if (r_s1.m[i]) w_msb = 6'(i);
    end
    w_shift = {{2{r_s1.e[11]}}, r_s1.e} - 14'd52 + 14'(FRAC_BITS);
    w_rsh   = -w_shift;
    w_top   = {w_shift[13], w_shift} + {9'd0, w_msb};
    w_wide  = '0;
    if (!w_shift[13]) begin
      if (w_shift < SH_LIM) w_wide = WW'(r_s1.m) << w_shift;
    end else if (w_rsh < 14'd53) begin
      w_wide = WW'(r_s1.m) >> w_rsh;
    end
    w_mag = w_wide[FIX_W-1:0];
    w_ovf = ~r_s1.is_zero &
            (((|r_s1.m) & (w_top >= TOP_LIM)) | (|w_wide[WW-1:FIX_W]));
  end

  logic [FIX_W-1:0] w_res;
  logic             w_res_ovf;
  logic             w_res_nan;

  always_comb begin
    w_res     = '0;
    w_res_ovf = 1'b0;
    w_res_nan = 1'b0;
    if (r_s2_nan) begin
      w_res_nan = 1'b1;
    end else if (r_s2_inf | r_s2_ovf) begin
      w_res     = r_s2_sign ? MIN_NEG : MAX_POS;
      w_res_ovf = 1'b1;
    end else begin
      w_res = r_s2_sign ? -r_s2_mag : r_s2_mag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_v3       <= 1'b0;
      r_s1       <= '0;
      r_s2_sign  <= 1'b0;
      r_s2_ovf   <= 1'b0;
      r_s2_inf   <= 1'b0;
      r_s2_nan   <= 1'b0;
      r_s2_mag   <= '0;
      r_out_data <= '0;
      r_out_ovf  <= 1'b0;
      r_out_nan  <= 1'b0;
    end else begin
      if (w_ld1) r_v1 <= input_valid;
      if (w_ld2) r_v2 <= r_v1;
      if (w_ld3) r_v3 <= r_v2;
      if (w_ld1 && input_valid) r_s1 <= w_unpk;
      if (w_ld2 && r_v1) begin
        r_s2_sign <= r_s1.sign;
        r_s2_ovf  <= w_ovf;
        r_s2_inf  <= r_s1.is_inf;
        r_s2_nan  <= r_s1.is_nan;
        r_s2_mag  <= w_mag;
      end
      if (w_ld3 && r_v2) begin
        r_out_data <= w_res;
        r_out_ovf  <= w_res_ovf;
        r_out_nan  <= w_res_nan;
      end
    end
  end

endmodule

// File: tb/tb_radix_converter_fwd.sv
// Directed-vector bench for radix_converter_fwd: single beats with
// latency checks, a stalled mixed-format burst and a mid-flight reset.
module tb_radix_converter_fwd;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  Ctrl_sig;
  logic        input_valid;
  logic        input_ready;
  logic [63:0] input_data;
  logic        output_valid;
  logic        output_ready;
  logic [63:0] output_data;
  logic        output_ovf;
  logic        output_nan;

  radix_converter_fwd #(.FIX_W(64), .FRAC_BITS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .Ctrl_sig     (Ctrl_sig),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data),
    .output_ovf   (output_ovf),
    .output_nan   (output_nan)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

  typedef struct {
    logic [1:0]  f;
    logic [63:0] d;
    logic [63:0] x;
    logic        o;
    logic        n;
  } vec_t;

  vec_t dv[17];
  vec_t bv[8];

  int n_chk  = 0;
  int n_pass = 0;
  int n_out  = 0;

  int          mode  = 0;
  logic        sb_en = 1'b0;
  logic [65:0] cur_exp;
  logic [65:0] q[$];
  logic        stall_p = 1'b0;
  logic [63:0] stall_d;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%h want 0x%h", tag, obs, exp);
  endtask

  // Downstream ready: 0 = always on, 1 = 1,0,1,1,0 pattern, 2 = held off.
  initial begin
    logic [4:0] pat;
    int         pi;
    pat = 5'b01101;
    pi  = 0;
    output_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mode)
        0: output_ready = 1'b1;
        1: begin
          output_ready = pat[pi];
          pi = (pi + 1) % 5;
        end
        default: output_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [65:0] e;
    if (sb_en && !rst) begin
      chk("burst.irdy", 64'(input_ready),
          64'(!(q.size() == 3 && !output_ready)));
      if (stall_p) begin
        chk("stall.valid", 64'(output_valid), 64'd1);
        chk("stall.data", output_data, stall_d);
      end
      stall_p = output_valid && !output_ready;
      stall_d = output_data;
      if (output_valid && output_ready) begin
        if (q.size() == 0) begin
          chk("burst.extra", 64'(output_valid), 64'd0);
        end else begin
          e = q.pop_front();
          chk($sformatf("burst%0d.data", n_out), output_data, e[63:0]);
          chk($sformatf("burst%0d.ovf", n_out), 64'(output_ovf), 64'(e[65]));
          chk($sformatf("burst%0d.nan", n_out), 64'(output_nan), 64'(e[64]));
          n_out++;
        end
      end
      if (input_valid && input_ready) q.push_back(cur_exp);
    end
  end

  task automatic send_one(input vec_t v, input int idx);
    int lat;
    @(posedge clk); #1;
    Ctrl_sig    = v.f;
    input_data  = v.d;
    input_valid = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d.rdy", idx), 64'(input_ready), 64'd1);
    @(posedge clk); #1;
    input_valid = 1'b0;
    Ctrl_sig    = ~v.f;
    input_data  = ~v.d;
    lat = 1;
    @(negedge clk);
    while (!output_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d.lat", idx), 64'(lat), 64'd3);
    chk($sformatf("v%0d.data", idx), output_data, v.x);
    chk($sformatf("v%0d.ovf", idx), 64'(output_ovf), 64'(v.o));
    chk($sformatf("v%0d.nan", idx), 64'(output_nan), 64'(v.n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int stale;

    dv[0]  = '{2'd0, 64'h3C00, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    dv[1]  = '{2'd1, 64'hBFC0_0000, 64'hFFFF_FFFE_8000_0000, 1'b0, 1'b0};
    dv[2]  = '{2'd1, 64'h3DCC_CCCD, 64'h0000_0000_1999_99A0, 1'b0, 1'b0};
    dv[3]  = '{2'd2, 64'h4270_0000_0000_0000, MAXP, 1'b1, 1'b0};
    dv[4]  = '{2'd2, 64'hC270_0000_0000_0000, MINN, 1'b1, 1'b0};
    dv[5]  = '{2'd0, 64'h0001, 64'h0000_0000_0000_0100, 1'b0, 1'b0};
    dv[6]  = '{2'd0, 64'h7E00, 64'h0, 1'b0, 1'b1};
    dv[7]  = '{2'd0, 64'hFC00, MINN, 1'b1, 1'b0};
    dv[8]  = '{2'd2, 64'h41D0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0};
    dv[9]  = '{2'd2, 64'h41E0_0000_0000_0000, MAXP, 1'b1, 1'b0};
    dv[10] = '{2'd2, 64'h3DF0_0000_0000_0000, 64'h1, 1'b0, 1'b0};
    dv[11] = '{2'd2, 64'h3DE0_0000_0000_0000, 64'h0, 1'b0, 1'b0};
    dv[12] = '{2'd3, 64'h3FF0_0000_0000_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    dv[13] = '{2'd1, 64'hDEAD_BEEF_8000_0000, 64'h0, 1'b0, 1'b0};
    dv[14] = '{2'd0, 64'h1234_5678_9ABC_7C00, MAXP, 1'b1, 1'b0};
    dv[15] = '{2'd2, 64'hFFF8_0000_0000_0000, 64'h0, 1'b0, 1'b1};
    dv[16] = '{2'd1, 64'hC700_0000, 64'hFFFF_8000_0000_0000, 1'b0, 1'b0};

    bv[0] = '{2'd0, 64'h3C00, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    bv[1] = '{2'd1, 64'hBFC0_0000, 64'hFFFF_FFFE_8000_0000, 1'b0, 1'b0};
    bv[2] = '{2'd2, 64'h4270_0000_0000_0000, MAXP, 1'b1, 1'b0};
    bv[3] = '{2'd0, 64'h0001, 64'h0000_0000_0000_0100, 1'b0, 1'b0};
    bv[4] = '{2'd1, 64'h3DCC_CCCD, 64'h0000_0000_1999_99A0, 1'b0, 1'b0};
    bv[5] = '{2'd2, 64'h41D0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0};
    bv[6] = '{2'd0, 64'hFC00, MINN, 1'b1, 1'b0};
    bv[7] = '{2'd1, 64'h7FC0_0000, 64'h0, 1'b0, 1'b1};

    rst         = 1'b1;
    input_valid = 1'b0;
    Ctrl_sig    = 2'd0;
    input_data  = '0;
    cur_exp     = '0;
    repeat (2) @(negedge clk);
    chk("rst.ovalid", 64'(output_valid), 64'd0);
    chk("rst.data", output_data, 64'd0);
    chk("rst.ovf", 64'(output_ovf), 64'd0);
    chk("rst.nan", 64'(output_nan), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst.irdy", 64'(input_ready), 64'd1);

    for (int i = 0; i < 17; i++) send_one(dv[i], i);

    // Mixed-format burst under a toggling downstream ready.
    @(posedge clk); #1;
    mode  = 1;
    sb_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      Ctrl_sig    = bv[i].f;
      input_data  = bv[i].d;
      input_valid = 1'b1;
      cur_exp     = {bv[i].o, bv[i].n, bv[i].x};
      w = 0;
      @(negedge clk);
      while (!input_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk($sformatf("burst%0d.acc", i), 64'(input_ready), 64'd1);
    end
    @(posedge clk); #1;
    input_valid = 1'b0;
    w = 0;
    while (q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("burst.drain", 64'(q.size()), 64'd0);
    chk("burst.count", 64'(n_out), 64'd8);
    sb_en = 1'b0;

    // Fill all three stages with downstream held off, then reset.
    mode = 2;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      Ctrl_sig    = dv[i].f;
      input_data  = dv[i].d;
      input_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("fill%0d.rdy", i), 64'(input_ready), 64'd1);
    end
    @(posedge clk); #1;
    input_valid = 1'b0;
    @(negedge clk);
    chk("full.ovalid", 64'(output_valid), 64'd1);
    chk("full.irdy", 64'(input_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async.ovalid", 64'(output_valid), 64'd0);
    chk("async.data", output_data, 64'd0);
    @(posedge clk); #1;
    rst  = 1'b0;
    mode = 0;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (output_valid) stale++;
    end
    chk("rst.stale", 64'(stale), 64'd0);
    send_one(dv[16], 99);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/radix_converter_fwd.md
Name: radix_converter_fwd

Overview:
Forward counterpart of the fixed-to-float output chain. Accepts one half-, single- or double-precision IEEE-754 value per beat and converts it to a signed fixed-point word for the SpMV datapath. Sits at the kernel input, between the float operand stream and the fixed-point MAC array. Pure RTL with no FP IP: a 3-stage elastic pipeline with valid/ready handshakes on both ends.

Parameters:
FIX_W, 64, output fixed-point width in bits (two's complement).
FRAC_BITS, 32, number of fractional bits in the output (Q(FIX_W-FRAC_BITS).FRAC_BITS).

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
Ctrl_sig  input  2  format of the current input beat: 2 = double, 1 = single, 0 = half, 3 = reserved (treated as double)
input_valid  input  1  input beat valid
input_ready  output  1  block can accept a beat
input_data  input  64  IEEE value; half in [15:0], single in [31:0], double in [63:0]; unused upper bits ignored
output_valid  output  1  result valid
output_ready  input  1  downstream accepts result
output_data  output  FIX_W  signed fixed-point result
output_ovf  output  1  result saturated (|value| out of range, or ±Inf)
output_nan  output  1  input was NaN; output_data forced to 0

Behaviour:
- Reset (async, rst=1): all stage valid bits cleared; output_valid=0, output_data=0, output_ovf=0, output_nan=0. input_ready=1 after reset release. Reset mid-operation discards all in-flight beats.
- Handshake: a beat transfers when valid&ready are high in the same cycle.
  - Stage k loads when it is empty or stage k+1 loads; stage 3 "loads onward" when output_ready=1.
  - input_ready = stage-1 load condition (combinational from output_ready through the chain; no loop).
  - output_valid stays high with stable data/flags until accepted.
- Ctrl_sig is sampled with each accepted beat and carried down the pipeline. It may change every cycle; each beat uses its own sampled format.
- Latency: 3 cycles from acceptance to output_valid with no backpressure. Throughput is 1 beat/cycle; bubbles collapse.
- Stage 1 (unpack): extract sign, biased exponent and fraction per format, then widen to a common form:
  - unbiased exponent E, 12-bit signed;
  - 53-bit mantissa M with hidden bit, fraction left-aligned to 52 bits.
  - Subnormal (exp=0, frac≠0): hidden bit 0, E = 1-bias.
  - Zero: M=0.
  - exp=all-ones: classify Inf (frac=0) or NaN (frac≠0).
  - Bias: 15 / 127 / 1023.
- Stage 2 (align): shift S = E - 52 + FRAC_BITS.
  - S ≥ 0: left shift. Overflow if M≠0 and (msb index of M)+S ≥ FIX_W-1.
  - S < 0: right shift, truncating toward zero. If -S ≥ 53, magnitude = 0.
- Stage 3 (sign/saturate):
  - Negate the magnitude if sign=1.
  - Overflow or Inf: positive → 0x7FF…F, negative → 0x800…0; output_ovf=1.
  - NaN: data 0, output_nan=1, output_ovf=0.
  - -0 → 0.
- Rounding is truncation toward zero only. No inexact flag.

Decomposition:
- Shared package spmv_radix_pkg:
  - format codes FMT_HALF=0, FMT_SINGLE=1, FMT_DOUBLE=2;
  - exponent widths and biases per format;
  - the common unpacked struct type {sign, E[11:0], M[52:0], is_inf, is_nan, is_zero}.
- One sub-module, fp_unpack: combinational stage-1 decode (format + raw bits → unpacked struct). The top owns the pipeline registers, the aligner and the saturation logic.

Test Plan (FIX_W=64, FRAC_BITS=32, output_ready=1 unless stated):
- Ctrl_sig=0, data 0x3C00 (half 1.0) → after 3 cycles output_data=0x0000_0001_0000_0000, ovf=0, nan=0.
- Ctrl_sig=1, data 0xBFC0_0000 (single -1.5) → 0xFFFF_FFFE_8000_0000. Ctrl_sig=1, data 0x3DCC_CCCD (0.1f) → 0x0000_0000_1999_99A0.
- Ctrl_sig=2, data 0x4270_0000_0000_0000 (2^40) → 0x7FFF_FFFF_FFFF_FFFF, ovf=1. Same with sign bit set → 0x8000_0000_0000_0000, ovf=1.
- Ctrl_sig=0: data 0x0001 (smallest subnormal, 2^-24) → 0x0000_0000_0000_0100. Data 0x7E00 (NaN) → 0, nan=1. Data 0xFC00 (-Inf) → 0x8000…0, ovf=1.
- Back-to-back burst of 8 beats with Ctrl_sig cycling 0,1,2 and output_ready toggling 1,0,1,1,0 → all 8 results in order, each correct for its own format. No drop or duplicate. output_data stable while stalled. input_ready=0 only when all 3 stages are full and output_ready=0.
- Assert rst for 1 cycle with 3 beats in flight → output_valid=0 immediately (async). No stale beats after release. The next accepted beat emerges with latency 3.
